voice_gain_mult: RTL and testbench
==================================

// Module: voice_gain_mult
// PURPOSE
//   Sequential shift-add multiplier that re-expands a normalised voice sample:
//   out = sample * (gain + 1). It is the inverse of the mixer's
//   divide-by-active-voices stage and sits between the voice normaliser and
//   the DAC/output scaler. Valid/ready on both sides; one operation in flight.
// PARAMETERS
//   DATA_W   16  width of sample in and sample out (unsigned)
//   GAIN_W    4  width of gain code; multiplier factor = gain + 1 (1..2^GAIN_W)
// PORTS
//   clk         in   1            system clock, all logic on rising edge
//   reset       in   1            synchronous, active-high reset
//   in_valid    in   1            request valid
//   in_ready    out  1            block can accept (high only in IDLE)
//   in_sample   in   DATA_W       unsigned multiplicand
//   in_gain     in   GAIN_W       gain code; factor = in_gain + 1
//   out_valid   out  1            result valid, held until out_ready
//   out_ready   in   1            downstream accepts result
//   out_sample  out  DATA_W       result (saturated or wrapped, see CONFIGURATION)
//   out_ovf     out  1            product exceeded 2^DATA_W-1
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=1, out_valid=0, out_sample=0, out_ovf=0.
//     Accumulator and bit counter cleared; in-flight operation discarded.
//   - All outputs registered. in_ready = (state==IDLE).
//   - States: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: on in_valid && in_ready edge, latch in_sample, factor=in_gain+1
//     (GAIN_W+1 bits), acc=0, cnt=0; go BUSY. Inputs are ignored after the
//     latch; in_gain/in_sample changes during BUSY have no effect.
//   - BUSY: one factor bit per cycle, LSB first. If the bit is set,
//     acc += sample << cnt. cnt++. Acc width = DATA_W+GAIN_W+1.
//     After GAIN_W+1 BUSY cycles go DONE.
//   - Latency: out_valid rises exactly GAIN_W+1 rising edges (5 at default)
//     after the accepting edge. The latency is fixed and does not depend on
//     the data.
//   - DONE: out_valid=1. out_sample and out_ovf are stable until
//     out_valid && out_ready. On that edge: out_valid=0, state=IDLE,
//     out_sample/out_ovf retain their last value.
//     in_ready is low in DONE, so no accept can happen in the same cycle.
//   - out_ovf = |acc[DATA_W+GAIN_W:DATA_W] at completion.
//   - Boundaries:
//     - sample=0 gives 0 with ovf=0.
//     - gain=0 passes the sample through unchanged.
//     - Max product (2^DATA_W-1)*2^GAIN_W is representable in acc without loss.
//   - reset asserted in BUSY or DONE: the next edge returns the block to the
//     reset values. No result is emitted.
//   - in_valid low, or in_valid asserted while not in IDLE: no effect.
// CONFIGURATION
//   MULT_SAT_EN defined:   out_sample = ovf ? {DATA_W{1'b1}} : acc[DATA_W-1:0]
//   MULT_SAT_EN undefined: out_sample = acc[DATA_W-1:0] (modulo 2^DATA_W wrap).
//     out_ovf is reported identically in both builds.
// TESTING
//   1 reset held 3 cycles -> in_ready=1, out_valid=0, out_sample=0, out_ovf=0
//   2 sample=3, gain=2 -> out_sample=9, ovf=0; out_valid high exactly 5 edges
//     after accept
//   3 sample=21, gain=0 -> 21; sample=100, gain=15 -> 1600; sample=0, gain=15 -> 0
//   4 sample=5000, gain=15 (80000) -> SAT build: 65535, ovf=1;
//     wrap build: 14464, ovf=1
//   5 out_ready low 10 cycles -> out_valid/out_sample/out_ovf stable, in_ready=0,
//     new in_valid ignored; out_ready=1 -> IDLE next edge, next op correct
//   6 reset pulsed on 3rd BUSY cycle -> next edge in_ready=1, out_valid=0,
//     outputs 0; no stray out_valid follows

Source files
------------

// File: rtl/voice_gain_mult_if.sv
// ---------------------------------------------------------------------------
// voice_gain_mult_if
//   Handshake/data bundle for voice_gain_mult.
//   Request side : in_valid, in_ready, in_sample[DATA_W], in_gain[GAIN_W]
//   Result side  : out_valid, out_ready, out_sample[DATA_W], out_ovf
//   modport master : the environment (drives requests, accepts results)
//   modport slave  : the multiplier block
// ---------------------------------------------------------------------------
interface voice_gain_mult_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;
  logic [GAIN_W-1:0] in_gain;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sample;
  logic              out_ovf;

  modport master (
    output in_valid, in_sample, in_gain, out_ready,
    input  in_ready, out_valid, out_sample, out_ovf
  );

  modport slave (
    input  in_valid, in_sample, in_gain, out_ready,
    output in_ready, out_valid, out_sample, out_ovf
  );
endinterface

// File: rtl/voice_gain_mult.sv
// ---------------------------------------------------------------------------
// voice_gain_mult
//   Sequential shift-add multiplier re-expanding a normalised voice sample:
//     out_sample = in_sample * (in_gain + 1)
//   One operation in flight; one factor bit consumed per cycle, LSB first.
//   Result appears GAIN_W+1 rising edges after the accepting edge.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : voice_gain_mult_if.slave
//            in_valid/in_ready/in_sample/in_gain  request handshake
//            out_valid/out_ready/out_sample/out_ovf result handshake
//
// Configuration
//   MULT_SAT_EN defined   : out_sample saturates to all-ones on overflow
//   MULT_SAT_EN undefined : out_sample is the product modulo 2^DATA_W
//   out_ovf is identical in both builds.
// ---------------------------------------------------------------------------
module voice_gain_mult #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 4
) (
  input logic              clk,
  input logic              reset,
  voice_gain_mult_if.slave bus
);

  // Accumulator holds the full (2^DATA_W-1) * 2^GAIN_W product without loss.
  localparam int unsigned ACC_W = DATA_W + GAIN_W + 1;
  localparam int unsigned CNT_W = (GAIN_W + 1 > 1) ? $clog2(GAIN_W + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAIN_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [DATA_W-1:0] sample_q,     sample_d;
  logic [GAIN_W:0]   factor_q,     factor_d;
  logic [ACC_W-1:0]  acc_q,        acc_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              in_ready_q,   in_ready_d;
  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_sample_q, out_sample_d;
  logic              out_ovf_q,    out_ovf_d;

  logic [ACC_W-1:0]  partial;
  logic [ACC_W-1:0]  acc_sum;
  logic              ovf_sum;
  logic [DATA_W-1:0] result;

  // Partial product for the current factor bit and the running sum it gives.
  // The final BUSY cycle registers the result straight from acc_sum so that
  // out_valid rises on the same edge that consumes the last factor bit.
  always_comb begin
    partial = '0;
    if (factor_q[cnt_q]) begin
      partial = ACC_W'(sample_q) << cnt_q;
    end
    acc_sum = acc_q + partial;
    ovf_sum = |acc_sum[ACC_W-1:DATA_W];
`ifdef MULT_SAT_EN
    result  = ovf_sum ? '1 : acc_sum[DATA_W-1:0];
`else
    result  = acc_sum[DATA_W-1:0];
`endif
  end

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    factor_d     = factor_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    out_ovf_d    = out_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sample_d   = bus.in_sample;
          factor_d   = {1'b0, bus.in_gain} + (GAIN_W + 1)'(1);
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          out_sample_d = result;
          out_ovf_d    = ovf_sum;
          out_valid_d  = 1'b1;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sample_q     <= '0;
      factor_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      factor_q     <= factor_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_voice_gain_mult.sv
// ---------------------------------------------------------------------------
// tb_voice_gain_mult
//   Directed cases with literal expectations, then randomized traffic with a
//   transaction-level reference model compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_voice_gain_mult;
  localparam int unsigned DW  = 16;
  localparam int unsigned GW  = 4;
  localparam int unsigned LAT = GW + 1;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_done;

  voice_gain_mult_if #(.DATA_W(DW), .GAIN_W(GW)) bus ();

  voice_gain_mult #(.DATA_W(DW), .GAIN_W(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic        m_ready;
  logic        m_valid;
  logic [15:0] m_sample;
  logic        m_ovf;
  int          m_countdown;
  logic [15:0] m_pend_sample;
  logic        m_pend_ovf;

  function automatic void expect_result(input int unsigned s, input int unsigned g,
                                        output logic [15:0] r, output logic o);
    longint unsigned p;
    p = longint'(s) * (longint'(g) + 1);
    o = (p > 65535);
`ifdef MULT_SAT_EN
    r = o ? 16'hFFFF : 16'(p % 65536);
`else
    r = 16'(p % 65536);
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid     = 1'b0;
      m_sample    = '0;
      m_ovf       = 1'b0;
      m_countdown = 0;
    end else if (m_valid) begin
      if (bus.out_ready) m_valid = 1'b0;
    end else if (m_countdown > 0) begin
      m_countdown--;
      if (m_countdown == 0) begin
        m_valid  = 1'b1;
        m_sample = m_pend_sample;
        m_ovf    = m_pend_ovf;
        n_done++;
      end
    end else if (bus.in_valid) begin
      expect_result(bus.in_sample, bus.in_gain, m_pend_sample, m_pend_ovf);
      m_countdown = LAT;
    end
    m_ready = !m_valid && (m_countdown == 0);
  end

  always @(negedge clk) begin
    chk("model_in_ready",   bus.in_ready,   m_ready);
    chk("model_out_valid",  bus.out_valid,  m_valid);
    chk("model_out_sample", bus.out_sample, m_sample);
    chk("model_out_ovf",    bus.out_ovf,    m_ovf);
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input int unsigned s, input int unsigned g,
                        input int unsigned exp_s, input int unsigned exp_o,
                        input int unsigned hold, input string tag);
    int lat;
    chk({tag, "_ready_before"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'(s);
    bus.in_gain   = 4'(g);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_sample = 16'($urandom);
    bus.in_gain   = 4'($urandom);
    chk({tag, "_ready_busy"}, bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bus.in_sample = 16'($urandom);
      bus.in_gain   = 4'($urandom);
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_sample"},  bus.out_sample, exp_s);
    chk({tag, "_ovf"},     bus.out_ovf, exp_o);
    for (int unsigned i = 0; i < hold; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'($urandom);
      bus.in_gain   = 4'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"},  bus.out_valid, 1);
      chk({tag, "_hold_sample"}, bus.out_sample, exp_s);
      chk({tag, "_hold_ovf"},    bus.out_ovf, exp_o);
      chk({tag, "_hold_ready"},  bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_after_valid"},  bus.out_valid, 0);
    chk({tag, "_after_ready"},  bus.in_ready, 1);
    chk({tag, "_after_sample"}, bus.out_sample, exp_s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        o;
    n_vec  = 0;
    n_err  = 0;
    n_done = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.in_gain   = '0;
    bus.out_ready = 1'b0;

    // reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   bus.in_ready, 1);
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_out_sample", bus.out_sample, 0);
    chk("rst_out_ovf",    bus.out_ovf, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // pin the model arithmetic itself
    expect_result(5000, 15, r, o);
`ifdef MULT_SAT_EN
    chk("model_pin_5000x16", r, 65535);
`else
    chk("model_pin_5000x16", r, 14464);
`endif
    chk("model_pin_ovf", o, 1);

    run_op(3,   2,  9,    0, 0, "s3g2");
    run_op(21,  0,  21,   0, 0, "s21g0");
    run_op(100, 15, 1600, 0, 0, "s100g15");
    run_op(0,   15, 0,    0, 0, "s0g15");
`ifdef MULT_SAT_EN
    run_op(5000, 15, 65535, 1, 0, "s5000g15");
    run_op(65535, 15, 65535, 1, 0, "smaxg15");
`else
    run_op(5000, 15, 14464, 1, 0, "s5000g15");
    run_op(65535, 15, 65520, 1, 0, "smaxg15");
`endif
    run_op(65535, 0, 65535, 0, 0, "smaxg0");

    // stalled result, then the next operation must still be correct
    run_op(1234, 3, 4936, 0, 10, "stall");
    run_op(7, 9, 70, 0, 0, "post_stall");

    // reset during the 3rd BUSY cycle
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'd400;
    bus.in_gain   = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready",   bus.in_ready, 1);
    chk("midrst_out_valid",  bus.out_valid, 0);
    chk("midrst_out_sample", bus.out_sample, 0);
    chk("midrst_out_ovf",    bus.out_ovf, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stray", bus.out_valid, 0);
    end
    run_op(11, 1, 22, 0, 0, "post_rst");

    // randomized traffic checked by the model on every cycle
    n_done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       bus.in_sample = 16'($urandom_range(0, 255));
        1:       bus.in_sample = 16'($urandom_range(0, 4095));
        2:       bus.in_sample = 16'($urandom);
        default: bus.in_sample = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      bus.in_gain   = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 599) == 0);
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("random_ops_completed", (n_done > 100) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
